// File: rtl/clkdiv_switch.sv
// clkdiv_switch: single-clock programmable clock divider.
// clkout is derived from clk by counting NSEL-selectable half-period lengths.
// Ratio changes and run/stop requests are applied only at the low-to-high
// period boundary, so clkout never produces a runt pulse. The only exception
// is a synchronous reset, which forces clkout low at once.
module clkdiv_switch #(
  parameter int NSEL = 4,
  parameter int SELW = 2,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 coldres_n,
  input  logic [NSEL*DW-1:0]   div_tbl,
  input  logic [SELW-1:0]      sel,
  input  logic                 en,
  output logic                 clkout,
  output logic                 clk_rise,
  output logic                 clk_fall,
  output logic [SELW-1:0]      cur_sel,
  output logic                 pending
);

  // NSEL may equal 2**SELW, so the bound needs one extra bit.
  localparam logic [SELW:0] NSEL_W = (SELW+1)'(NSEL);

  logic [SELW-1:0] sel_q;
  logic [DW-1:0]   cnt;

  logic            clkout_d;
  logic            rise_d;
  logic            fall_d;
  logic [SELW-1:0] cur_sel_d;
  logic [DW-1:0]   cnt_d;

  // Reload value for a half-period: H(k)-1, with an entry of 0 treated as H=1.
  // The table is looked up with a loop so that indices beyond NSEL-1 are safe.
  function automatic logic [DW-1:0] reload_val(
    input logic [NSEL*DW-1:0] tbl,
    input logic [SELW-1:0]    k
  );
    logic [DW-1:0] h;
    h = '0;
    for (int i = 0; i < NSEL; i++) begin
      if (SELW'(i) == k) h = tbl[i*DW +: DW];
    end
    if (h == '0) return '0;
    return h - DW'(1);
  endfunction

  // Requested ratio register; out-of-range requests are ignored.
  always_ff @(posedge clk) begin
    if (!coldres_n) begin
      sel_q <= '0;
    end else if ({1'b0, sel} < NSEL_W) begin
      sel_q <= sel;
    end
  end

  // Next-state: boundary handling, falling edge, or plain count-down.
  always_comb begin
    clkout_d  = clkout;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    cur_sel_d = cur_sel;
    cnt_d     = cnt;
    if (cnt == '0) begin
      if (!clkout) begin
        // Period boundary: adopt the requested ratio even while stopped so
        // that the first period after restart already uses it.
        cur_sel_d = sel_q;
        if (en) begin
          clkout_d = 1'b1;
          rise_d   = 1'b1;
          cnt_d    = reload_val(div_tbl, sel_q);
        end
      end else begin
        // End of high phase: the matching low phase always follows.
        clkout_d = 1'b0;
        fall_d   = 1'b1;
        cnt_d    = reload_val(div_tbl, cur_sel);
      end
    end else begin
      cnt_d = cnt - DW'(1);
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (!coldres_n) begin
      clkout   <= 1'b0;
      clk_rise <= 1'b0;
      clk_fall <= 1'b0;
      cur_sel  <= '0;
      cnt      <= '0;
    end else begin
      clkout   <= clkout_d;
      clk_rise <= rise_d;
      clk_fall <= fall_d;
      cur_sel  <= cur_sel_d;
      cnt      <= cnt_d;
    end
  end

  assign pending = (sel_q != cur_sel);

endmodule

// File: tb/tb_clkdiv_switch.sv
// Directed testbench for clkdiv_switch (NSEL=4, SELW=3, DW=8).
module tb_clkdiv_switch;

  localparam int NSEL = 4;
  localparam int SELW = 3;
  localparam int DW   = 8;

  logic                clk;
  logic                coldres_n;
  logic [NSEL*DW-1:0]  div_tbl;
  logic [SELW-1:0]     sel;
  logic                en;
  logic                clkout;
  logic                clk_rise;
  logic                clk_fall;
  logic [SELW-1:0]     cur_sel;
  logic                pending;

  int n_checks;
  int n_fail;

  clkdiv_switch #(.NSEL(NSEL), .SELW(SELW), .DW(DW)) dut (
    .clk       (clk),
    .coldres_n (coldres_n),
    .div_tbl   (div_tbl),
    .sel       (sel),
    .en        (en),
    .clkout    (clkout),
    .clk_rise  (clk_rise),
    .clk_fall  (clk_fall),
    .cur_sel   (cur_sel),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) for a rising strobe with the given ratio in effect.
  task automatic wait_rise(input logic [SELW-1:0] s);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (clk_rise === 1'b1 && cur_sel === s) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_rise: no rise with cur_sel=%0d within 100 clks", s);
    end
  endtask

  // Reset holds everything low; first period after release uses H(0)=1.
  task automatic test_reset();
    coldres_n = 1'b0;
    sel       = 3'd2;
    en        = 1'b1;
    div_tbl   = {8'd5, 8'd3, 8'd2, 8'd1};
    repeat (3) @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise, clk_fall, cur_sel, pending} !== {3'b000, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got clkout/rise/fall=%b%b%b cur_sel=%0d pending=%b, want 000 0 0",
               clkout, clk_rise, clk_fall, cur_sel, pending);
    end
    coldres_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise, clk_fall, cur_sel, pending} !== {3'b110, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_first_rise: got %b%b%b cur_sel=%0d pending=%b, want 110 0 1",
               clkout, clk_rise, clk_fall, cur_sel, pending);
    end
    @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise, clk_fall} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_first_fall: got %b%b%b, want 001", clkout, clk_rise, clk_fall);
    end
    @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise, cur_sel, pending} !== {2'b11, 3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_second_rise: got clkout=%b rise=%b cur_sel=%0d pending=%b, want 1 1 2 0",
               clkout, clk_rise, cur_sel, pending);
    end
  endtask

  // H=1: clkout toggles every clk, rise every 2 clks.
  task automatic test_ratio1();
    coldres_n = 1'b0;
    sel       = 3'd0;
    @(negedge clk);
    coldres_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({clkout, clk_rise, clk_fall, cur_sel} !== {((k % 2) == 1) ? 3'b110 : 3'b001, 3'd0}) begin
        n_fail++;
        $display("FAIL ratio1 k=%0d: got %b%b%b cur_sel=%0d, want %b sel 0",
                 k, clkout, clk_rise, clk_fall, cur_sel, ((k % 2) == 1) ? 3'b110 : 3'b001);
      end
    end
  endtask

  // Switch 0->3 during a high phase; new 5/5 period starts at next rise.
  task automatic test_switch();
    logic [2:0] exp;
    @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise} !== 2'b11) begin
      n_fail++;
      $display("FAIL switch_pre_high: got clkout=%b rise=%b, want 1 1", clkout, clk_rise);
    end
    sel = 3'd3;
    @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise, clk_fall, cur_sel, pending} !== {3'b001, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL switch_pending: got %b%b%b cur_sel=%0d pending=%b, want 001 0 1",
               clkout, clk_rise, clk_fall, cur_sel, pending);
    end
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      exp = {((j < 5) || (j == 10)), ((j == 0) || (j == 10)), (j == 5)};
      n_checks++;
      if ({clkout, clk_rise, clk_fall, cur_sel, pending} !== {exp, 3'd3, 1'b0}) begin
        n_fail++;
        $display("FAIL switch_h5 j=%0d: got %b%b%b cur_sel=%0d pending=%b, want %b 3 0",
                 j, clkout, clk_rise, clk_fall, cur_sel, pending, exp);
      end
    end
  endtask

  // Drop en just after a rise with H=3: 3 high, 3 low, then parked low.
  task automatic test_stop();
    logic [2:0] exp;
    sel = 3'd2;
    wait_rise(3'd2);
    en = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      exp = {(j <= 2), 1'b0, (j == 3)};
      n_checks++;
      if ({clkout, clk_rise, clk_fall} !== exp) begin
        n_fail++;
        $display("FAIL stop j=%0d: got %b%b%b, want %b", j, clkout, clk_rise, clk_fall, exp);
      end
    end
    n_checks++;
    if (cur_sel !== 3'd2) begin
      n_fail++;
      $display("FAIL stop_cur_sel: got %0d, want 2", cur_sel);
    end
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise, clk_fall} !== 3'b110) begin
      n_fail++;
      $display("FAIL restart_rise: got %b%b%b, want 110", clkout, clk_rise, clk_fall);
    end
  endtask

  // Active entry edited to 0 -> H=1 from next reload; out-of-range sel ignored.
  task automatic test_zero_entry();
    logic [2:0] exp_seq [6];
    exp_seq = '{3'b100, 3'b100, 3'b001, 3'b110, 3'b001, 3'b110};
    div_tbl = {8'd5, 8'd0, 8'd2, 8'd1};
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      n_checks++;
      if ({clkout, clk_rise, clk_fall} !== exp_seq[j]) begin
        n_fail++;
        $display("FAIL zero_entry j=%0d: got %b%b%b, want %b",
                 j, clkout, clk_rise, clk_fall, exp_seq[j]);
      end
    end
    sel = 3'd5;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise, cur_sel, pending} !== {2'b11, 3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL sel5_ignored: got clkout=%b rise=%b cur_sel=%0d pending=%b, want 1 1 2 0",
               clkout, clk_rise, cur_sel, pending);
    end
    sel = 3'd4;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cur_sel, pending} !== {3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL sel4_ignored: got cur_sel=%0d pending=%b, want 2 0", cur_sel, pending);
    end
  endtask

  // Reset in the middle of an H=5 high phase, then normal restart.
  task automatic test_reset_mid();
    div_tbl = {8'd5, 8'd3, 8'd2, 8'd1};
    sel     = 3'd3;
    wait_rise(3'd3);
    repeat (2) @(negedge clk);
    n_checks++;
    if (clkout !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_high: got clkout=%b, want 1", clkout);
    end
    coldres_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise, clk_fall, cur_sel, pending} !== {3'b000, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got %b%b%b cur_sel=%0d pending=%b, want 000 0 0",
               clkout, clk_rise, clk_fall, cur_sel, pending);
    end
    coldres_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise, clk_fall, cur_sel, pending} !== {3'b110, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_restart: got %b%b%b cur_sel=%0d pending=%b, want 110 0 1",
               clkout, clk_rise, clk_fall, cur_sel, pending);
    end
    @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise, clk_fall} !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_restart_fall: got %b%b%b, want 001", clkout, clk_rise, clk_fall);
    end
    @(negedge clk);
    n_checks++;
    if ({clkout, clk_rise, cur_sel, pending} !== {2'b11, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_restart_switch: got clkout=%b rise=%b cur_sel=%0d pending=%b, want 1 1 3 0",
               clkout, clk_rise, cur_sel, pending);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    coldres_n = 1'b0;
    sel       = '0;
    en        = 1'b1;
    div_tbl   = {8'd5, 8'd3, 8'd2, 8'd1};
    test_reset();
    test_ratio1();
    test_switch();
    test_stop();
    test_zero_entry();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
